// File: rtl/wb_retire_queue.sv
// In-order write-back retire queue: commits GPR/CSR writes, exceptions and ertn from the head.
// Optional macro WB_DEBUG_TRACE_EN adds debug trace ports and a retired-instruction counter.
module wb_retire_queue #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int DEPTH  = 2,
    parameter int BUS_W  = 4*DATA_W+RA_W+34
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_to_wb_valid,
    input  logic [BUS_W-1:0]      mem_to_wb_bus,
    output logic                  wb_allowin,
    input  logic                  wb_stall,
    output logic                  rf_we,
    output logic [RA_W-1:0]       rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [(2**RA_W)-1:0]  rf_pending,
    output logic                  csr_re,
    output logic [13:0]           csr_num,
    input  logic [DATA_W-1:0]     csr_rvalue,
    output logic                  csr_we,
    output logic [DATA_W-1:0]     csr_wmask,
    output logic [DATA_W-1:0]     csr_wvalue,
    output logic                  wb_ex,
    output logic [5:0]            wb_ecode,
    output logic [8:0]            wb_esubcode,
    output logic [DATA_W-1:0]     wb_ex_pc,
    output logic                  ertn_flush,
    output logic [DATA_W-1:0]     era_out,
    output logic                  wb_ex_pending
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [DATA_W-1:0]     debug_wb_pc,
    output logic [3:0]            debug_wb_rf_we,
    output logic [RA_W-1:0]       debug_wb_rf_wnum,
    output logic [DATA_W-1:0]     debug_wb_rf_wdata,
    output logic [31:0]           debug_retire_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    // Field positions inside mem_to_wb_bus, counted from the LSB.
    localparam int ESUB_LSB  = 0;
    localparam int ECODE_LSB = 9;
    localparam int EXEN_BIT  = 15;
    localparam int ERTN_BIT  = 16;
    localparam int CWV_LSB   = 17;
    localparam int CWM_LSB   = 17 + DATA_W;
    localparam int CNUM_LSB  = 17 + 2*DATA_W;
    localparam int CWE_BIT   = 31 + 2*DATA_W;
    localparam int CRE_BIT   = 32 + 2*DATA_W;
    localparam int PC_LSB    = 33 + 2*DATA_W;
    localparam int WDATA_LSB = 33 + 3*DATA_W;
    localparam int WADDR_LSB = 33 + 4*DATA_W;
    localparam int RFWE_BIT  = 33 + 4*DATA_W + RA_W;

    logic [BUS_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [BUS_W-1:0] w_head;
    logic             w_head_vld;
    logic             w_retire;
    logic             w_push;
    logic             w_flush;
    logic             w_head_ex;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_head     = r_mem[r_head];
    assign w_head_vld = (r_count != '0) & ~reset;
    assign w_retire   = w_head_vld & ~wb_stall;
    assign w_head_ex  = w_head[EXEN_BIT];

    assign wb_allowin = (r_count != DEPTH_C);
    assign w_push     = mem_to_wb_valid & wb_allowin;
    assign w_flush    = wb_ex | ertn_flush;

    assign rf_we       = w_retire & w_head[RFWE_BIT] & ~w_head_ex;
    assign csr_we      = w_retire & w_head[CWE_BIT] & ~w_head_ex;
    assign wb_ex       = w_retire & w_head_ex;
    assign ertn_flush  = w_retire & w_head[ERTN_BIT] & ~w_head_ex;

    assign csr_re      = w_head_vld & w_head[CRE_BIT];
    assign csr_num     = w_head[CNUM_LSB +: 14];
    assign csr_wmask   = w_head[CWM_LSB +: DATA_W];
    assign csr_wvalue  = w_head[CWV_LSB +: DATA_W];
    assign rf_waddr    = w_head[WADDR_LSB +: RA_W];
    assign rf_wdata    = w_head[CRE_BIT] ? csr_rvalue : w_head[WDATA_LSB +: DATA_W];
    assign wb_ecode    = w_head[ECODE_LSB +: 6];
    assign wb_esubcode = w_head[ESUB_LSB +: 9];
    assign wb_ex_pc    = w_head[PC_LSB +: DATA_W];
    assign era_out     = csr_rvalue;

    // Scoreboard covers every occupied slot, the retiring head included.
    always_comb begin
        rf_pending    = '0;
        wb_ex_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            int ofs;
            ofs = (i >= int'(r_head)) ? (i - int'(r_head)) : (i + DEPTH - int'(r_head));
            if (ofs < int'(r_count)) begin
                if (r_mem[i][RFWE_BIT])
                    rf_pending[r_mem[i][WADDR_LSB +: RA_W]] = 1'b1;
                if (r_mem[i][EXEN_BIT] | r_mem[i][ERTN_BIT])
                    wb_ex_pending = 1'b1;
            end
        end
        rf_pending[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_tail] <= mem_to_wb_bus;
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= ptr_inc(r_tail);
            if (w_retire)
                r_head <= ptr_inc(r_head);
            if (w_push && !w_retire)
                r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_retire)
                r_count <= r_count - CNT_W'(1);
        end
    end

`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_retire_cnt <= '0;
        else if (w_retire)
            r_retire_cnt <= r_retire_cnt + 32'd1;
    end

    assign debug_wb_pc       = wb_ex_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
    assign debug_retire_cnt  = r_retire_cnt;
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed bench for wb_retire_queue: DEPTH=2 instance for functional steps, DEPTH=3 instance for wrap.
module tb_wb_retire_queue;

    localparam int DATA_W = 32;
    localparam int RA_W   = 5;
    localparam int BUS_W  = 4*DATA_W+RA_W+34;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              valid, stall, allowin;
    logic [BUS_W-1:0]  bus;
    logic              rf_we, csr_re, csr_we, wb_ex, ertn_flush, ex_pend;
    logic [RA_W-1:0]   rf_waddr;
    logic [31:0]       rf_wdata, csr_rvalue, csr_wmask, csr_wvalue, ex_pc, era_out, rf_pend;
    logic [13:0]       csr_num;
    logic [5:0]        ecode;
    logic [8:0]        esub;

    logic              valid3, stall3, allowin3;
    logic [BUS_W-1:0]  bus3;
    logic              rf_we3, csr_re3, csr_we3, wb_ex3, ertn3, ex_pend3;
    logic [RA_W-1:0]   rf_waddr3;
    logic [31:0]       rf_wdata3, csr_rvalue3, csr_wmask3, csr_wvalue3, ex_pc3, era_out3, rf_pend3;
    logic [13:0]       csr_num3;
    logic [5:0]        ecode3;
    logic [8:0]        esub3;

    wb_retire_queue #(.DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(2)) u_dut (
        .clk(clk), .reset(reset), .mem_to_wb_valid(valid), .mem_to_wb_bus(bus),
        .wb_allowin(allowin), .wb_stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .rf_pending(rf_pend), .csr_re(csr_re), .csr_num(csr_num),
        .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(ecode), .wb_esubcode(esub),
        .wb_ex_pc(ex_pc), .ertn_flush(ertn_flush), .era_out(era_out),
        .wb_ex_pending(ex_pend)
    );

    wb_retire_queue #(.DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(3)) u_dut3 (
        .clk(clk), .reset(reset), .mem_to_wb_valid(valid3), .mem_to_wb_bus(bus3),
        .wb_allowin(allowin3), .wb_stall(stall3), .rf_we(rf_we3), .rf_waddr(rf_waddr3),
        .rf_wdata(rf_wdata3), .rf_pending(rf_pend3), .csr_re(csr_re3), .csr_num(csr_num3),
        .csr_rvalue(csr_rvalue3), .csr_we(csr_we3), .csr_wmask(csr_wmask3),
        .csr_wvalue(csr_wvalue3), .wb_ex(wb_ex3), .wb_ecode(ecode3), .wb_esubcode(esub3),
        .wb_ex_pc(ex_pc3), .ertn_flush(ertn3), .era_out(era_out3),
        .wb_ex_pending(ex_pend3)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    endtask

    function automatic logic [BUS_W-1:0] mk(
        input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc,
        input logic cre, input logic cwe, input logic [13:0] cnum, input logic [31:0] wm,
        input logic [31:0] wv, input logic ertn, input logic exen, input logic [5:0] ec,
        input logic [8:0] es);
        return {we, wa, wd, pc, cre, cwe, cnum, wm, wv, ertn, exen, ec, es};
    endfunction

    function automatic logic [BUS_W-1:0] gpr(input logic [4:0] wa, input logic [31:0] wd);
        return mk(1'b1, wa, wd, 32'h1C00_0000, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0,
                  1'b0, 1'b0, 6'h0, 9'h0);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; stall = 1'b0; bus = '0; csr_rvalue = '0;
        valid3 = 1'b0; stall3 = 1'b0; bus3 = '0; csr_rvalue3 = '0;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        chk("rst_allowin", allowin, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_csr_we", csr_we, 0);
        chk("rst_wb_ex", wb_ex, 0);
        chk("rst_ertn", ertn_flush, 0);
        chk("rst_pending", rf_pend, 0);
        chk("rst_ex_pending", ex_pend, 0);
        chk("rst_allowin3", allowin3, 1);

        // Back-to-back pushes, one-cycle latency.
        valid = 1'b1; bus = gpr(5'd3, 32'h11); #1;
        chk("b2b_empty_rf_we", rf_we, 0);
        cyc();
        bus = gpr(5'd7, 32'h22); #1;
        chk("b2b_rf_we0", rf_we, 1);
        chk("b2b_waddr0", rf_waddr, 3);
        chk("b2b_wdata0", rf_wdata, 32'h11);
        chk("b2b_pend0", rf_pend, 32'h0000_0008);
        cyc();
        valid = 1'b0; #1;
        chk("b2b_rf_we1", rf_we, 1);
        chk("b2b_waddr1", rf_waddr, 7);
        chk("b2b_wdata1", rf_wdata, 32'h22);
        chk("b2b_pend1", rf_pend, 32'h0000_0080);
        cyc();
        chk("b2b_idle", rf_we, 0);

        // Stall fills the queue; full queue refuses even while retiring.
        stall = 1'b1; valid = 1'b1; bus = gpr(5'd3, 32'h33); #1;
        chk("stl_allow0", allowin, 1);
        cyc();
        bus = gpr(5'd7, 32'h77); #1;
        chk("stl_allow1", allowin, 1);
        chk("stl_no_we", rf_we, 0);
        cyc();
        bus = gpr(5'd9, 32'h99); #1;
        chk("stl_full", allowin, 0);
        chk("stl_pend", rf_pend, 32'h0000_0088);
        chk("stl_no_we2", rf_we, 0);
        cyc();
        stall = 1'b0; #1;
        chk("stl_ret0_we", rf_we, 1);
        chk("stl_ret0_addr", rf_waddr, 3);
        chk("stl_full_retiring", allowin, 0);
        cyc();
        chk("stl_ret1_addr", rf_waddr, 7);
        chk("stl_ret1_data", rf_wdata, 32'h77);
        chk("stl_allow_again", allowin, 1);
        cyc();
        valid = 1'b0; #1;
        chk("stl_ret2_we", rf_we, 1);
        chk("stl_ret2_addr", rf_waddr, 9);
        chk("stl_ret2_data", rf_wdata, 32'h99);
        cyc();
        chk("stl_empty", rf_we, 0);

        // Exception at head flushes the younger entry.
        stall = 1'b1; valid = 1'b1;
        bus = mk(1'b1, 5'd5, 32'h55, 32'h1C00_0100, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0,
                 1'b0, 1'b1, 6'h0B, 9'h003);
        cyc();
        bus = gpr(5'd6, 32'h66); #1;
        chk("ex_pending", ex_pend, 1);
        chk("ex_stalled", wb_ex, 0);
        cyc();
        valid = 1'b0; stall = 1'b0; #1;
        chk("ex_pulse", wb_ex, 1);
        chk("ex_ecode", ecode, 32'h0B);
        chk("ex_esub", esub, 32'h003);
        chk("ex_pc", ex_pc, 32'h1C00_0100);
        chk("ex_no_rf_we", rf_we, 0);
        chk("ex_pend_both", rf_pend, 32'h0000_0060);
        cyc();
        chk("ex_single", wb_ex, 0);
        chk("ex_young_we", rf_we, 0);
        chk("ex_flushed_pend", rf_pend, 0);
        chk("ex_flushed_expend", ex_pend, 0);
        chk("ex_flushed_allow", allowin, 1);
        cyc();
        chk("ex_young_never", rf_we, 0);

        // CSR read-modify-write at head.
        valid = 1'b1; csr_rvalue = 32'hDEAD_BEEF;
        bus = mk(1'b1, 5'd4, 32'h1234, 32'h1C00_0140, 1'b1, 1'b1, 14'h005, 32'hFFFF_0000,
                 32'hCAFE_0000, 1'b0, 1'b0, 6'h0, 9'h0);
        cyc();
        valid = 1'b0; #1;
        chk("csr_rf_we", rf_we, 1);
        chk("csr_rdata", rf_wdata, 32'hDEAD_BEEF);
        chk("csr_re", csr_re, 1);
        chk("csr_num", csr_num, 32'h005);
        chk("csr_we", csr_we, 1);
        chk("csr_wmask", csr_wmask, 32'hFFFF_0000);
        chk("csr_wvalue", csr_wvalue, 32'hCAFE_0000);
        cyc();
        chk("csr_we_done", csr_we, 0);

        // ertn at head while a push is offered.
        valid = 1'b1;
        bus = mk(1'b0, 5'd0, 32'h0, 32'h1C00_0180, 1'b1, 1'b0, 14'h006, 32'h0, 32'h0,
                 1'b1, 1'b0, 6'h0, 9'h0);
        cyc();
        bus = gpr(5'd8, 32'h88); csr_rvalue = 32'h1C00_0200; #1;
        chk("ertn_pulse", ertn_flush, 1);
        chk("ertn_era", era_out, 32'h1C00_0200);
        chk("ertn_no_ex", wb_ex, 0);
        chk("ertn_allow", allowin, 1);
        cyc();
        valid = 1'b0; #1;
        chk("ertn_single", ertn_flush, 0);
        chk("ertn_drop_pend", rf_pend, 0);
        chk("ertn_drop_we", rf_we, 0);
        cyc();
        chk("ertn_drop_never", rf_we, 0);

        // Reset with a full queue.
        stall = 1'b1; valid = 1'b1; bus = gpr(5'd10, 32'hA0);
        cyc();
        bus = gpr(5'd11, 32'hB0);
        cyc();
        valid = 1'b0; #1;
        chk("rstq_full", allowin, 0);
        reset = 1'b1; stall = 1'b0; #1;
        chk("rstq_rf_we", rf_we, 0);
        chk("rstq_csr_we", csr_we, 0);
        chk("rstq_wb_ex", wb_ex, 0);
        cyc();
        reset = 1'b0; #1;
        chk("rstq_allow", allowin, 1);
        chk("rstq_pend", rf_pend, 0);
        chk("rstq_rf_we_after", rf_we, 0);
        chk("rstq_wb_ex_after", wb_ex, 0);

        // DEPTH=3: ten push/retire pairs wrap the pointers several times.
        valid3 = 1'b1; bus3 = gpr(5'd1, 32'h100); #1;
        chk("wrap_first_empty", rf_we3, 0);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k < 10) bus3 = gpr(5'(k + 1), 32'h100 + 32'(k));
            else valid3 = 1'b0;
            #1;
            chk("wrap_we", rf_we3, 1);
            chk("wrap_addr", rf_waddr3, 32'(k));
            chk("wrap_data", rf_wdata3, 32'h100 + 32'(k - 1));
        end
        cyc();
        chk("wrap_idle", rf_we3, 0);

        // DEPTH=3 fill under stall, then drain in order.
        stall3 = 1'b1; valid3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus3 = gpr(5'(20 + k), 32'h200 + 32'(k));
            cyc();
        end
        valid3 = 1'b0; #1;
        chk("fill3_full", allowin3, 0);
        chk("fill3_pend", rf_pend3, 32'h0070_0000);
        stall3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("drain3_addr", rf_waddr3, 32'(20 + k));
            chk("drain3_data", rf_wdata3, 32'h200 + 32'(k));
            cyc();
        end
        chk("drain3_empty", rf_we3, 0);
        chk("drain3_allow", allowin3, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
